// File: rtl/core_types_pkg.sv
// +----------------------------------------------------------------------+
// | core_types_pkg: core-wide sizing constants shared by the backend.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package core_types_pkg;

  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 7;

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | wb_rr_arbiter: one-hot grant per cycle. Round-robin when               |
// | PRF_WB_ARBITER_ROUND_ROBIN_EN is defined, else fixed lowest-index.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_rr_arbiter #(
  parameter int REQ_COUNT = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [REQ_COUNT-1:0] req,
  output logic [REQ_COUNT-1:0] gnt
);

`ifdef PRF_WB_ARBITER_ROUND_ROBIN_EN
  logic [REQ_COUNT-1:0]   r_ptr;
  logic [REQ_COUNT-1:0]   w_ptr_next;
  logic [2*REQ_COUNT-1:0] w_dreq;
  logic [2*REQ_COUNT-1:0] w_dgnt;

  // Doubled request vector lets the borrow chain wrap past the top index.
  always_comb begin
    w_dreq = {req, req};
    w_dgnt = w_dreq & ~(w_dreq - {{REQ_COUNT{1'b0}}, r_ptr});
    gnt    = w_dgnt[REQ_COUNT-1:0] | w_dgnt[2*REQ_COUNT-1:REQ_COUNT];
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (|gnt) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        w_ptr_next[(i + 1) % REQ_COUNT] = gnt[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ptr <= REQ_COUNT'(1);
    end else begin
      r_ptr <= w_ptr_next;
    end
  end
`else
  logic w_unused_clk_rst;

  assign w_unused_clk_rst = CLK ^ nRST;
  assign gnt              = req & (~req + REQ_COUNT'(1));
`endif

endmodule

`default_nettype wire

// File: rtl/prf_wb_arbiter.sv
// +----------------------------------------------------------------------+
// | prf_wb_arbiter: per-bank writeback arbitration into the banked PRF.   |
// | Option macro: PRF_WB_ARBITER_ROUND_ROBIN_EN (see wb_rr_arbiter).      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module prf_wb_arbiter
  import core_types_pkg::*;
#(
  parameter int WB_PIPE_COUNT     = 4,
  parameter int LOG_WB_PIPE_COUNT = $clog2(WB_PIPE_COUNT)
) (
  input  logic                                            CLK,
  input  logic                                            nRST,
  input  logic [WB_PIPE_COUNT-1:0]                        WB_valid_by_pipe,
  input  logic [WB_PIPE_COUNT-1:0][31:0]                  WB_data_by_pipe,
  input  logic [WB_PIPE_COUNT-1:0][LOG_PR_COUNT-1:0]      WB_PR_by_pipe,
  input  logic [WB_PIPE_COUNT-1:0][LOG_ROB_ENTRIES-1:0]   WB_ROB_index_by_pipe,
  output logic [WB_PIPE_COUNT-1:0]                        WB_ready_by_pipe,
  output logic [PRF_BANK_COUNT-1:0]                       prf_write_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]     prf_write_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][31:0]                 prf_write_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0]                       bus_forward_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]     bus_forward_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][31:0]                 bus_forward_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0]                       complete_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]  complete_ROB_index_by_bank
);

  logic [PRF_BANK_COUNT-1:0][WB_PIPE_COUNT-1:0]     w_req_by_bank;
  logic [PRF_BANK_COUNT-1:0][WB_PIPE_COUNT-1:0]     w_gnt_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_WB_PIPE_COUNT-1:0] w_gnt_idx_by_bank;
  logic [PRF_BANK_COUNT-1:0]                        w_any_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]      w_pr_by_bank;
  logic [PRF_BANK_COUNT-1:0][31:0]                  w_data_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]   w_rob_by_bank;

  always_comb begin
    w_req_by_bank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int p = 0; p < WB_PIPE_COUNT; p++) begin
        w_req_by_bank[b][p] = WB_valid_by_pipe[p] &&
          (WB_PR_by_pipe[p][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

  generate
    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank_arb
      wb_rr_arbiter #(
        .REQ_COUNT (WB_PIPE_COUNT)
      ) u_arb (
        .CLK  (CLK),
        .nRST (nRST),
        .req  (w_req_by_bank[b]),
        .gnt  (w_gnt_by_bank[b])
      );
    end
  endgenerate

  // Each pipe targets one bank, so the OR of per-bank grants stays one-hot per pipe.
  always_comb begin
    WB_ready_by_pipe = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      WB_ready_by_pipe = WB_ready_by_pipe | w_gnt_by_bank[b];
    end
  end

  always_comb begin
    w_gnt_idx_by_bank = '0;
    w_any_by_bank     = '0;
    w_pr_by_bank      = '0;
    w_data_by_bank    = '0;
    w_rob_by_bank     = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int p = 0; p < WB_PIPE_COUNT; p++) begin
        if (w_gnt_by_bank[b][p]) begin
          w_gnt_idx_by_bank[b] = LOG_WB_PIPE_COUNT'(p);
        end
      end
      w_any_by_bank[b]  = |w_gnt_by_bank[b];
      w_pr_by_bank[b]   = WB_PR_by_pipe[w_gnt_idx_by_bank[b]];
      w_data_by_bank[b] = WB_data_by_pipe[w_gnt_idx_by_bank[b]];
      w_rob_by_bank[b]  = WB_ROB_index_by_pipe[w_gnt_idx_by_bank[b]];
    end
  end

  // PR 0 is hard-wired zero: it still completes in the ROB but never writes or forwards.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prf_write_valid_by_bank    <= '0;
      prf_write_PR_by_bank       <= '0;
      prf_write_data_by_bank     <= '0;
      bus_forward_valid_by_bank  <= '0;
      bus_forward_PR_by_bank     <= '0;
      bus_forward_data_by_bank   <= '0;
      complete_valid_by_bank     <= '0;
      complete_ROB_index_by_bank <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        prf_write_valid_by_bank[b]    <= w_any_by_bank[b] && (w_pr_by_bank[b] != '0);
        prf_write_PR_by_bank[b]       <= w_pr_by_bank[b];
        prf_write_data_by_bank[b]     <= w_data_by_bank[b];
        bus_forward_valid_by_bank[b]  <= w_any_by_bank[b] && (w_pr_by_bank[b] != '0);
        bus_forward_PR_by_bank[b]     <= w_pr_by_bank[b];
        bus_forward_data_by_bank[b]   <= w_data_by_bank[b];
        complete_valid_by_bank[b]     <= w_any_by_bank[b];
        complete_ROB_index_by_bank[b] <= w_rob_by_bank[b];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/prf_wb_arbiter.md
# prf_wb_arbiter

Writeback receiver between the execution pipelines and the banked physical register file. Each cycle, every PRF bank grants at most one pipe's writeback request. Each bank has an independent arbiter. The grant is returned to the pipe as `WB_ready`. Granted writes are registered and then drive the bank write ports, the per-bank bus-forward broadcast and the ROB complete notifications.

## Interface
Parameters:
- `WB_PIPE_COUNT`, default 4: number of writeback requesters.
- `LOG_WB_PIPE_COUNT`, default `$clog2(WB_PIPE_COUNT)`: width of the pipe index.

Ports:
- `CLK`  in  1  clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `WB_valid_by_pipe`  in  `[WB_PIPE_COUNT]`  writeback request.
- `WB_data_by_pipe`  in  `[WB_PIPE_COUNT][32]`  result data.
- `WB_PR_by_pipe`  in  `[WB_PIPE_COUNT][LOG_PR_COUNT]`  destination physical register.
- `WB_ROB_index_by_pipe`  in  `[WB_PIPE_COUNT][LOG_ROB_ENTRIES]`  ROB entry.
- `WB_ready_by_pipe`  out  `[WB_PIPE_COUNT]`  grant; combinational, same cycle as request.
- `prf_write_valid_by_bank`  out  `[PRF_BANK_COUNT]`  bank write enable.
- `prf_write_PR_by_bank`  out  `[PRF_BANK_COUNT][LOG_PR_COUNT]`  write address.
- `prf_write_data_by_bank`  out  `[PRF_BANK_COUNT][32]`  write data.
- `bus_forward_valid_by_bank`  out  `[PRF_BANK_COUNT]`  broadcast valid.
- `bus_forward_PR_by_bank`  out  `[PRF_BANK_COUNT][LOG_PR_COUNT]`  broadcast tag.
- `bus_forward_data_by_bank`  out  `[PRF_BANK_COUNT][32]`  broadcast data.
- `complete_valid_by_bank`  out  `[PRF_BANK_COUNT]`  ROB complete notification.
- `complete_ROB_index_by_bank`  out  `[PRF_BANK_COUNT][LOG_ROB_ENTRIES]`  completing ROB entry.

## Operation
- **Target bank:** the target bank of a request is `WB_PR_by_pipe[p][LOG_PRF_BANK_COUNT-1:0]`.
- **Per-bank request vector:**
  - The request vector for bank b is: `WB_valid_by_pipe[p]` & (target bank == b).
  - A pipe always targets exactly one bank.
  - Per-bank grants are therefore one-hot across pipes, and their OR forms `WB_ready_by_pipe`.
- **Arbitration:**
  - Round-robin with a per-bank `WB_PIPE_COUNT`-bit one-hot priority pointer.
  - The search starts at the pointer position and wraps from index `WB_PIPE_COUNT-1` to 0.
  - On a grant to pipe g, the pointer rotates to g+1 (mod `WB_PIPE_COUNT`).
  - With no grant, the pointer holds.
- **Output register:**
  - The granted pipe's PR, data and ROB index are registered per bank.
  - Every registered output updates every cycle.
  - A bank with no grant registers valid=0 on all three of its valid outputs.
- **PR 0 handling:**
  - PR 0 is the hard-wired zero.
  - A granted request to PR 0 asserts `complete_valid` but drives `prf_write_valid`=0 and `bus_forward_valid`=0.
- **No backpressure on outputs:** a registered grant always completes the following cycle.
- **Losing requesters:**
  - A losing requester sees `WB_ready`=0 and must hold its request.
  - Hold is the pipe's responsibility; this block keeps no request state.
- **Simultaneous requests:** requests to different banks in the same cycle are all granted.

## Timing
- **Request cycle (N):** a request present in cycle N whose pipe wins arbitration gets `WB_ready`=1 in cycle N.
- **Output cycle (N+1):** the write port, bus forward and complete outputs are valid in cycle N+1.
- **Data freshness:** `bus_forward_data_by_bank` is valid in cycle N+1 only and must not be held. Consumers sample it exactly one cycle after a bus-forward issue.
- **Throughput:** one write per bank per cycle. Peak is `PRF_BANK_COUNT` writes per cycle.
- **Reset values (all outputs and the pointer):**
  - All valids 0.
  - All PR, data and ROB index outputs 0.
  - All priority pointers at pipe 0.
- **Reset mid-operation:**
  - Registered grants are discarded and no write occurs.
  - `WB_ready` is a function of inputs only, so it may assert during reset.
  - Any write granted during reset is lost.
  - The system must hold all `WB_valid` low while `nRST` is low.

## Configuration
- **Macro:** `PRF_WB_ARBITER_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration as described under Operation.
- **Undefined:**
  - Fixed priority: the lowest pipe index wins.
  - Pointer registers are not instantiated.
  - All other behaviour and timing is identical.

## Structure
- **Shared package constants:** `PRF_BANK_COUNT`, `LOG_PRF_BANK_COUNT`, `LOG_PR_COUNT` and `LOG_ROB_ENTRIES` come from `core_types_pkg`. No new typedefs are needed.
- **Sub-module `wb_rr_arbiter`:**
  - Parameter `REQ_COUNT`.
  - Ports: request vector in, one-hot grant out, `CLK` and `nRST` for the pointer.
  - One instance per bank.
  - Contains the configuration macro guard.
- **Top level:** bank decode, grant OR-reduction to `WB_ready_by_pipe`, per-bank data mux and output registers.

## Test plan
Configuration for all scenarios: 4 pipes, 4 banks.
1. **Single write:** pipe 1 writes PR 6, data 0xDEADBEEF, ROB 3.
   - Cycle N: `WB_ready[1]`=1.
   - Cycle N+1: bank 2 has `prf_write_valid`=1, PR 6, data 0xDEADBEEF; `bus_forward_valid[2]`=1; `complete_ROB_index[2]`=3.
   - Cycle N+2: all bank 2 valids are 0.
2. **Bank conflict with rotation:** pipes 0 and 2 hold requests to PR 4 and PR 8 (both bank 0) continuously.
   - Grants alternate 0, 2, 0, 2.
   - Each loser's `WB_ready`=0 in the cycles it loses.
   - With the macro undefined, pipe 0 wins every cycle.
3. **Parallel banks:** all four pipes request PRs 4, 5, 6, 7 in the same cycle.
   - All four `WB_ready`=1.
   - All four banks write in N+1.
4. **PR 0 write:** pipe 3 writes PR 0, ROB 9.
   - `WB_ready[3]`=1.
   - N+1: `complete_valid[0]`=1 with ROB 9; `prf_write_valid[0]`=0; `bus_forward_valid[0]`=0.
5. **Wrap-around:** bank 1 pointer at pipe 3; pipes 0 and 3 request.
   - Pipe 3 is granted and the pointer wraps to 0.
   - Next cycle pipe 0 is granted.
6. **Reset mid-operation:** assert `nRST` in the cycle after a grant.
   - All outputs go to 0 immediately.
   - After deassertion, pointers are at 0 and no stale write appears.
